// File: rtl/dec_stage.sv
// Registered MIPS decode stage: decoder, 32 x DW register file, output pipeline
// register with stall/flush and load-use bubble. Define DEC_BYPASS_EN for write-through reads.
module dec_stage #(
    parameter int DW  = 32,
    parameter int PCW = 32
) (
    input  logic           Clock,
    input  logic           nReset,
    input  logic           InValid,
    input  logic [31:0]    Instruction,
    input  logic [PCW-1:0] PCAddrIncIn,
    input  logic           Stall,
    input  logic           Flush,
    input  logic           RegWriteIn,
    input  logic [4:0]     RAddrIn,
    input  logic [DW-1:0]  RData,
    output logic           Hold,
    output logic           OutValid,
    output logic [DW-1:0]  ImmData,
    output logic [DW-1:0]  RsData,
    output logic [DW-1:0]  RtData,
    output logic [PCW-1:0] PCAddrIncOut,
    output logic [4:0]     RAddrOut,
    output logic           Branch,
    output logic           Jump,
    output logic           MemRead,
    output logic           MemtoReg,
    output logic           ALUOp,
    output logic           MULOp,
    output logic           MemWrite,
    output logic           ALUSrc,
    output logic           RegWriteOut,
    output logic [5:0]     ALUfunc,
    output logic [4:0]     Shamt
);

    typedef struct packed {
        logic branch;
        logic jump;
        logic mem_read;
        logic mem_to_reg;
        logic alu_op;
        logic mul_op;
        logic mem_write;
        logic alu_src;
        logic reg_write;
    } ctrl_t;

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm16;

    assign opcode = Instruction[31:26];
    assign rs     = Instruction[25:21];
    assign rt     = Instruction[20:16];
    assign rd     = Instruction[15:11];
    assign shamt  = Instruction[10:6];
    assign funct  = Instruction[5:0];
    assign imm16  = Instruction[15:0];

    ctrl_t      dec_ctrl;
    logic       dec_reg_dst, dec_shift_sel, dec_unsgn;
    logic [5:0] dec_alu_func;
    logic [4:0] dec_shamt;

    always_comb begin
        dec_ctrl      = '0;
        dec_reg_dst   = 1'b0;
        dec_shift_sel = 1'b0;
        dec_unsgn     = 1'b0;
        dec_alu_func  = 6'h00;
        dec_shamt     = 5'd0;
        case (opcode)
            6'h00: begin
                dec_reg_dst     = 1'b1;
                dec_ctrl.alu_op = 1'b1;
                dec_alu_func    = funct;
                dec_shamt       = shamt;
                if (funct == 6'h08) dec_ctrl.jump = 1'b1;
                else                dec_ctrl.reg_write = 1'b1;
            end
            6'h1C: begin
                dec_reg_dst        = 1'b1;
                dec_ctrl.mul_op    = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                dec_alu_func       = funct;
            end
            6'h02: dec_ctrl.jump = 1'b1;
            6'h04, 6'h05: begin
                dec_ctrl.branch = 1'b1;
                dec_alu_func    = 6'h23;
            end
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                // Logical immediates zero-extend; lui reuses the OR path with the shifted immediate.
                unique case (opcode[2:0])
                    3'd0: dec_alu_func = 6'h20;
                    3'd1: dec_alu_func = 6'h21;
                    3'd2: dec_alu_func = 6'h2A;
                    3'd3: dec_alu_func = 6'h2B;
                    3'd4: begin dec_alu_func = 6'h24; dec_unsgn = 1'b1; end
                    3'd5: begin dec_alu_func = 6'h25; dec_unsgn = 1'b1; end
                    3'd6: begin dec_alu_func = 6'h26; dec_unsgn = 1'b1; end
                    3'd7: begin dec_alu_func = 6'h25; dec_shift_sel = 1'b1; end
                    default: dec_alu_func = 6'h00;
                endcase
            end
            6'h23: begin
                dec_ctrl.mem_read   = 1'b1;
                dec_ctrl.mem_to_reg = 1'b1;
                dec_ctrl.alu_src    = 1'b1;
                dec_ctrl.reg_write  = 1'b1;
                dec_alu_func        = 6'h21;
            end
            6'h2B: begin
                dec_ctrl.mem_write = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
                dec_alu_func       = 6'h21;
            end
            default: dec_ctrl = '0;
        endcase
    end

    logic [DW-1:0] imm_ext;

    always_comb begin
        if (dec_shift_sel)  imm_ext = DW'({imm16, 16'h0000});
        else if (dec_unsgn) imm_ext = DW'(imm16);
        else                imm_ext = DW'($signed(imm16));
    end

    logic [DW-1:0] rf_q [32];
    logic [DW-1:0] rf_d [32];

    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_rf
            if (gi == 0) begin : g_zero
                assign rf_d[gi] = '0;
            end else begin : g_entry
                assign rf_d[gi] = (RegWriteIn && (RAddrIn == 5'(gi))) ? RData : rf_q[gi];
            end
            always_ff @(posedge Clock or negedge nReset) begin
                if (!nReset) rf_q[gi] <= '0;
                else         rf_q[gi] <= rf_d[gi];
            end
        end
    endgenerate

    logic [DW-1:0] rs_val, rt_val;

    always_comb begin
        rs_val = rf_q[rs];
        rt_val = rf_q[rt];
`ifdef DEC_BYPASS_EN
        if (RegWriteIn && (RAddrIn != 5'd0) && (RAddrIn == rs)) rs_val = RData;
        if (RegWriteIn && (RAddrIn != 5'd0) && (RAddrIn == rt)) rt_val = RData;
`endif
    end

    logic           valid_q, valid_d;
    ctrl_t          ctrl_q, ctrl_d;
    logic [DW-1:0]  imm_q, imm_d, rs_data_q, rs_data_d, rt_data_q, rt_data_d;
    logic [PCW-1:0] pc_q, pc_d;
    logic [4:0]     raddr_q, raddr_d, shamt_q, shamt_d;
    logic [5:0]     func_q, func_d;
    logic           hazard;

    // A registered load whose destination is read by the incoming instruction.
    assign hazard = valid_q && ctrl_q.mem_read && (raddr_q != 5'd0) && InValid &&
                    ((raddr_q == rs) || (raddr_q == rt));
    assign Hold   = ~Flush & (Stall | hazard);

    always_comb begin
        valid_d   = valid_q;
        ctrl_d    = ctrl_q;
        imm_d     = imm_q;
        rs_data_d = rs_data_q;
        rt_data_d = rt_data_q;
        pc_d      = pc_q;
        raddr_d   = raddr_q;
        shamt_d   = shamt_q;
        func_d    = func_q;
        if (Flush) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end else if (Stall) begin
            valid_d = valid_q;
        end else if (hazard) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end else begin
            valid_d   = InValid;
            ctrl_d    = InValid ? dec_ctrl : '0;
            imm_d     = imm_ext;
            rs_data_d = rs_val;
            rt_data_d = rt_val;
            pc_d      = PCAddrIncIn;
            raddr_d   = dec_reg_dst ? rd : rt;
            shamt_d   = dec_shamt;
            func_d    = dec_alu_func;
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            valid_q   <= 1'b0;
            ctrl_q    <= '0;
            imm_q     <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            pc_q      <= '0;
            raddr_q   <= 5'd0;
            shamt_q   <= 5'd0;
            func_q    <= 6'd0;
        end else begin
            valid_q   <= valid_d;
            ctrl_q    <= ctrl_d;
            imm_q     <= imm_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            pc_q      <= pc_d;
            raddr_q   <= raddr_d;
            shamt_q   <= shamt_d;
            func_q    <= func_d;
        end
    end

    assign OutValid     = valid_q;
    assign ImmData      = imm_q;
    assign RsData       = rs_data_q;
    assign RtData       = rt_data_q;
    assign PCAddrIncOut = pc_q;
    assign RAddrOut     = raddr_q;
    assign ALUfunc      = func_q;
    assign Shamt        = shamt_q;
    assign Branch       = ctrl_q.branch;
    assign Jump         = ctrl_q.jump;
    assign MemRead      = ctrl_q.mem_read;
    assign MemtoReg     = ctrl_q.mem_to_reg;
    assign ALUOp        = ctrl_q.alu_op;
    assign MULOp        = ctrl_q.mul_op;
    assign MemWrite     = ctrl_q.mem_write;
    assign ALUSrc       = ctrl_q.alu_src;
    assign RegWriteOut  = ctrl_q.reg_write;

endmodule

// File: doc/dec_stage.md
# dec_stage

Registered decode pipeline stage and successor to the combinational decode stage. It decodes a 32-bit MIPS-format instruction, reads a register file of parametrised data width and captures all decode results in an output pipeline register with valid, stall and flush control. It also detects load-use hazards and inserts a bubble. It sits between fetch (IF) and execute (EX), and register-file writes arrive from writeback.

## Interface
- DW, 32, data width of the register file, immediate and operand outputs; legal values 32 or 64
- PCW, 32, width of the incremented PC passed through
- Clock  in  1  rising-edge clock
- nReset  in  1  asynchronous, active-low reset
- InValid  in  1  Instruction/PCAddrIncIn hold a valid fetch
- Instruction  in  32  instruction word
- PCAddrIncIn  in  PCW  PC+4 of Instruction
- Stall  in  1  downstream cannot accept; hold output register
- Flush  in  1  squash input instruction and output register
- RegWriteIn  in  1  writeback write enable
- RAddrIn  in  5  writeback register address
- RData  in  DW  writeback data
- Hold  out  1  combinational; fetch must re-present the same instruction next cycle
- OutValid  out  1  output register holds a real instruction
- ImmData, RsData, RtData  out  DW  immediate, rs and rt operands
- PCAddrIncOut  out  PCW  registered PC+4
- RAddrOut  out  5  destination register (rt or rd per RegDst)
- Branch, Jump, MemRead, MemtoReg, ALUOp, MULOp, MemWrite, ALUSrc, RegWriteOut  out  1 each  registered control
- ALUfunc  out  6  ALU function; Shamt  out  5  shift amount

## Operation
- Decode uses the existing decoder, signextend and mux cells. The register file is 32 × DW; r0 always reads 0 and writes to it are ignored.
- ImmData:
  - ShiftSel=0: Instruction[15:0] sign- or zero-extended to DW per Unsgnsel.
  - ShiftSel=1: {Instruction[15:0],16'h0} zero-extended to DW.
- Hazard is asserted when all of the following hold:
  - OutValid=1 and MemRead=1 and RAddrOut≠0;
  - InValid=1;
  - RAddrOut equals Instruction[25:21] or Instruction[20:16].
- Hold = ~Flush & (Stall | hazard).
- Priority per cycle is nReset > Flush > Stall > hazard > load.
  - Flush: OutValid←0 and the input is discarded. Other outputs are don't-care and must not be asserted as valid.
  - Stall (no Flush): all output registers keep their values.
  - Hazard (no Stall/Flush): bubble. OutValid←0 and all control outputs ←0. The instruction is not consumed; fetch re-presents it. The next cycle has no hazard because the bubble holds no load.
  - Otherwise: outputs ← decode of the input and OutValid←InValid. If InValid=0, control outputs ←0.
- Register-file writes occur on every Clock edge where RegWriteIn=1 and RAddrIn≠0, independent of Stall/Flush/Hold.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N appears on the outputs after edge N.
- Throughput is one instruction per cycle when there is no stall or hazard. A load-use costs exactly 1 bubble cycle.
- Reset value of every registered output is 0 (OutValid=0, all data/control/address = 0). All 32 register-file entries reset to 0.
- Hold is combinational from Stall, Flush, Instruction and the output register, with no path from RData.
- Reset mid-operation clears the output register and register file immediately. Hold drops to 0 once the output register is cleared.
- Simultaneous Flush and hazard: Flush wins, Hold=0 and no bubble is recorded.

## Configuration
- DEC_BYPASS_EN defined:
  - If a register-file write and an operand read hit the same nonzero address in the same cycle, the captured RsData/RtData is RData (write-through).
- Undefined:
  - The captured value is the pre-write register content.
  - EX forwarding or the compiler must cover this case.

## Test plan
- Reset: nReset low with InValid=1 → all outputs 0, Hold=0; after release with no writes, RsData=RtData=0 for any address.
- Write then read: write r5=0x1234_5678, next cycle decode `addu r1,r5,r5` → after 1 edge OutValid=1, RsData=RtData=0x1234_5678, RAddrOut=1, RegWriteOut=1.
- Load-use: `lw r8,0(r2)` followed by `add r9,r8,r3` → Hold=1 for one cycle, one bubble (OutValid=0, MemRead=0), then add issues with RAddrOut=9.
- Stall/Flush: Stall=1 for 3 cycles → outputs frozen and Hold=1; Stall=1 with Flush=1 → next OutValid=0 and Hold=0.
- Immediates (DW=64): `lui r4,0x8001` → ImmData=0x0000_0000_8001_0000; `addi` with imm 0xFFFF → ImmData=0xFFFF_FFFF_FFFF_FFFF.
- Bypass: same-cycle write r7=0xAA and read r7 → RsData=0xAA with DEC_BYPASS_EN; old value (0 after reset) without it.
